shift_seq_ctrl: RTL and testbench

Sequencing controller for the team's 4-bit universal shift register used as a pattern/sequence generator. It accepts a command (seed value, shift count, feedback source) over a valid/ready handshake and drives the register's mode selects through load, shift-N and hold phases. It then signals completion. The block embeds the register and sits between a host sequencer and any logic consuming the generated pattern.

---
 rtl/shift_seq_pkg.sv | 38 +++
 rtl/shift_seq_ctrl_if.sv | 29 ++
 rtl/univ_shreg4.sv | 27 ++
 rtl/shift_seq_ctrl.sv | 106 ++++++++++
 tb/tb_shift_seq_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift-sequence controller and its register.
package shift_seq_pkg;

    // Controller phases.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Mode select driven onto {s1,s0} of the universal register.
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

    // Source of the left-serial input while shifting.
    typedef enum logic [1:0] {
        FB_ZERO = 2'b00,
        FB_ROT  = 2'b01,
        FB_SEQ  = 2'b10,
        FB_EXT  = 2'b11
    } fb_t;

    // Left-serial-in bit for the next shift; q is {QA,QB,QC,QD}.
    function automatic logic lin_mux(input fb_t fb, input logic [3:0] q, input logic sin);
        logic qa, qb, qc, qd;
        {qa, qb, qc, qd} = q;
        case (fb)
            FB_ZERO: return 1'b0;
            FB_ROT:  return qa;
            FB_SEQ:  return ~(qd | qc) | (qc | qb);
            default: return sin;
        endcase
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Host-side bundle: command handshake, run control and generated-pattern outputs.
interface shift_seq_ctrl_if #(
    parameter int CNT_W = 4
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       load_val;
    logic [CNT_W-1:0] shift_cnt;
    logic [1:0]       fb_sel;
    logic             sin;
    logic             abort;
    logic [3:0]       q;
    logic             s1;
    logic             s0;
    logic             busy;
    logic             done;

    // Host sequencer side.
    modport master (
        output cmd_valid, load_val, shift_cnt, fb_sel, sin, abort,
        input  cmd_ready, q, s1, s0, busy, done
    );

    // Controller side.
    modport slave (
        input  cmd_valid, load_val, shift_cnt, fb_sel, sin, abort,
        output cmd_ready, q, s1, s0, busy, done
    );
endinterface

// File: rtl/univ_shreg4.sv
// 4-bit universal shift register: hold, shift-left (QA<-QB<-QC<-QD<-lin), parallel load.
module univ_shreg4
    import shift_seq_pkg::*;
(
    input  logic       clk,
    input  logic       CLR,
    input  mode_t      mode,
    input  logic [3:0] d,
    input  logic       lin,
    output logic [3:0] q
);

    // Register update selected by mode; async clear to zero.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            q <= 4'b0000;
        end else begin
            case (mode)
                MODE_SHL:  q <= {q[2:0], lin};
                MODE_LOAD: q <= d;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencing controller: accepts a seed/count/feedback command, then drives the
// embedded register through load, N left shifts and a one-cycle done phase.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input logic             clk,
    input logic             CLR,
    shift_seq_ctrl_if.slave bus
);

    state_t           state, state_nx;
    logic [3:0]       seed_q;
    logic [CNT_W-1:0] cnt_q;
    fb_t              fb_q;
    logic [CNT_W-1:0] ctr;
    mode_t            mode;
    logic             busy;
    logic             done;
    logic             lin;
    logic [3:0]       q;
    logic             accept;

    assign accept = (state == ST_IDLE) && bus.cmd_valid;

    // State register, latched command fields and shift counter.
    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            state  <= ST_IDLE;
            seed_q <= 4'b0000;
            cnt_q  <= '0;
            fb_q   <= FB_ZERO;
            ctr    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                seed_q <= bus.load_val;
                cnt_q  <= bus.shift_cnt;
                fb_q   <= fb_t'(bus.fb_sel);
            end
            if (!bus.abort) begin
                if (state == ST_LOAD)
                    ctr <= cnt_q;
                else if (state == ST_SHIFT)
                    ctr <= ctr - 1'b1;
            end
        end
    end

    // Next-state and output decode; abort forces hold and a return to idle.
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_nx = state;
        mode     = MODE_HOLD;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (bus.cmd_valid)
                    state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                mode     = MODE_LOAD;
                state_nx = (cnt_q == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                mode = MODE_SHL;
                if (ctr == CNT_W'(1))
                    state_nx = ST_DONE;
            end
            default: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
        endcase
        if ((state != ST_IDLE) && bus.abort) begin
            state_nx = ST_IDLE;
            mode     = MODE_HOLD;
            done     = 1'b0;
        end
    end

    // Left-serial input from the live register contents and latched source.
    always_comb begin
        lin = lin_mux(fb_q, q, bus.sin);
    end

    univ_shreg4 u_shreg (
        .clk  (clk),
        .CLR  (CLR),
        .mode (mode),
        .d    (seed_q),
        .lin  (lin),
        .q    (q)
    );

    assign bus.q         = q;
    assign bus.s1        = mode[1];
    assign bus.s0        = mode[0];
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.cmd_ready = ~busy;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed scenarios plus randomized
// commands, each compared cycle by cycle against a behavioural pattern model.
module tb_shift_seq_ctrl;

    localparam int CNT_W = 4;

    logic clk;
    logic CLR;
    int   n_checks;
    int   n_fail;

    shift_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

    shift_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .CLR (CLR),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mode_of();
        return 8'({bus.s1, bus.s0});
    endfunction

    // Next left-serial bit from the rules for each feedback source; q = {QA,QB,QC,QD}.
    function automatic logic model_lin(input logic [1:0] fb, input logic [3:0] q, input logic s);
        case (fb)
            2'b00:   return 1'b0;
            2'b01:   return q[3];
            2'b10:   return ~(q[0] | q[1]) | (q[1] | q[2]);
            default: return s;
        endcase
    endfunction

    // One command from acceptance to first idle cycle. abort_at=k raises abort in
    // shift cycle k (after k-1 shifts); 0 means run to completion. Entered and left
    // shortly after a rising edge, in an idle cycle.
    task automatic run_cmd(input logic [3:0] seed, input int cnt, input logic [1:0] fb,
                           input int abort_at, input bit abort_on_accept, input bit noise,
                           input bit use_pat, input logic [15:0] sin_pat,
                           output logic [3:0] q_end);
        logic [3:0] eq;
        logic       s;
        // cycle 0: accept
        bus.cmd_valid = 1'b1;
        bus.load_val  = seed;
        bus.shift_cnt = cnt[CNT_W-1:0];
        bus.fb_sel    = fb;
        bus.abort     = abort_on_accept;
        bus.sin       = 1'($urandom);
        #1;
        check("accept_ready", 8'(bus.cmd_ready), 8'd1);
        check("accept_mode", mode_of(), 8'd0);
        @(posedge clk); #1;
        // cycle 1: load; scramble inputs to show they are latched / ignored
        bus.abort     = 1'b0;
        bus.fb_sel    = ~fb;
        bus.cmd_valid = noise;
        if (noise) begin
            bus.load_val  = ~seed;
            bus.shift_cnt = CNT_W'($urandom);
        end
        #1;
        check("load_mode", mode_of(), 8'd3);
        check("load_busy", 8'(bus.busy), 8'd1);
        check("load_ready", 8'(bus.cmd_ready), 8'd0);
        check("load_done", 8'(bus.done), 8'd0);
        @(posedge clk); #1;
        eq = seed;
        for (int k = 1; k <= cnt; k++) begin
            s = use_pat ? sin_pat[k-1] : 1'($urandom);
            bus.sin = s;
            bus.fb_sel = 2'($urandom);
            if (k == abort_at) bus.abort = 1'b1;
            #1;
            check("shift_q", 8'(bus.q), 8'(eq));
            check("shift_busy", 8'(bus.busy), 8'd1);
            check("shift_done", 8'(bus.done), 8'd0);
            if (k == abort_at) begin
                check("abort_mode", mode_of(), 8'd0);
                @(posedge clk); #1;
                bus.abort     = 1'b0;
                bus.cmd_valid = 1'b0;
                #1;
                check("abort_q", 8'(bus.q), 8'(eq));
                check("abort_busy", 8'(bus.busy), 8'd0);
                check("abort_ready", 8'(bus.cmd_ready), 8'd1);
                check("abort_done", 8'(bus.done), 8'd0);
                q_end = eq;
                return;
            end
            check("shift_mode", mode_of(), 8'd2);
            eq = {eq[2:0], model_lin(fb, eq, s)};
            @(posedge clk); #1;
        end
        // done cycle
        bus.cmd_valid = 1'b0;
        #1;
        check("done_pulse", 8'(bus.done), 8'd1);
        check("done_mode", mode_of(), 8'd0);
        check("done_busy", 8'(bus.busy), 8'd1);
        check("done_q", 8'(bus.q), 8'(eq));
        @(posedge clk); #1; #1;
        check("idle_ready", 8'(bus.cmd_ready), 8'd1);
        check("idle_done", 8'(bus.done), 8'd0);
        check("idle_q", 8'(bus.q), 8'(eq));
        q_end = eq;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] qf;
        n_checks = 0;
        n_fail   = 0;
        CLR           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.load_val  = 4'b0000;
        bus.shift_cnt = '0;
        bus.fb_sel    = 2'b00;
        bus.sin       = 1'b0;
        bus.abort     = 1'b0;

        // Reset state
        #12;
        check("rst_q", 8'(bus.q), 8'd0);
        check("rst_busy", 8'(bus.busy), 8'd0);
        check("rst_mode", mode_of(), 8'd0);
        check("rst_done", 8'(bus.done), 8'd0);
        CLR = 1'b1;
        #1;
        check("rst_ready", 8'(bus.cmd_ready), 8'd1);
        @(posedge clk); #1;

        // Abort alone in idle is ignored
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        #1;
        check("idle_abort_busy", 8'(bus.busy), 8'd0);
        check("idle_abort_ready", 8'(bus.cmd_ready), 8'd1);

        // Rotate: 1000, 4 shifts
        run_cmd(4'b1000, 4, 2'b01, 0, 1'b0, 1'b1, 1'b0, 16'h0, qf);
        check("rot_final", 8'(qf), 8'h08);

        // Sequence feedback: 0001, 3 shifts, back-to-back with previous
        run_cmd(4'b0001, 3, 2'b10, 0, 1'b0, 1'b0, 1'b0, 16'h0, qf);
        check("seq_final", 8'(bus.q), 8'h0B);

        // Zero count, then another command back-to-back
        run_cmd(4'b0110, 0, 2'b01, 0, 1'b0, 1'b1, 1'b0, 16'h0, qf);
        check("zero_q", 8'(bus.q), 8'h06);

        // Abort after two shifts
        run_cmd(4'b1111, 8, 2'b00, 3, 1'b0, 1'b0, 1'b0, 16'h0, qf);
        check("abort_held", 8'(bus.q), 8'h0C);

        // Abort together with cmd_valid in idle: command still accepted
        run_cmd(4'b0000, 4, 2'b11, 0, 1'b1, 1'b0, 1'b1, 16'b1101, qf);
        check("ext_final", 8'(bus.q), 8'h0B);

        // Async reset mid-shift
        bus.cmd_valid = 1'b1;
        bus.load_val  = 4'b1010;
        bus.shift_cnt = CNT_W'(8);
        bus.fb_sel    = 2'b01;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("midrun_busy_pre", 8'(bus.busy), 8'd1);
        CLR = 1'b0;
        #1;
        check("midrun_rst_q", 8'(bus.q), 8'd0);
        check("midrun_rst_busy", 8'(bus.busy), 8'd0);
        check("midrun_rst_mode", mode_of(), 8'd0);
        check("midrun_rst_done", 8'(bus.done), 8'd0);
        @(posedge clk); #2;
        CLR = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_done", 8'(bus.done), 8'd0);
            check("post_rst_ready", 8'(bus.cmd_ready), 8'd1);
        end

        // Randomized commands against the model
        for (int i = 0; i < 20; i++) begin
            int c;
            int ab;
            c  = int'($urandom_range(0, 15));
            ab = (c > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, c)) : 0;
            run_cmd(4'($urandom), c, 2'($urandom), ab, 1'($urandom), 1'($urandom),
                    1'b0, 16'h0, qf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
